// File: rtl/lab2_proc_multi_drop_unit.sv
`default_nettype none
//============================================================================
// Module   : lab2_proc_multi_drop_unit
// Purpose  : Sits between the imem response port and the F stage and
//            discards responses that belong to squashed fetches. A
//            saturating pending-drop counter lets several squashed
//            fetches be in flight at once.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            drop, drop_num  - squash event and number of responses to kill
//            in_msg/val/rdy  - response stream from memory
//            out_msg/val/rdy - response stream to the F stage
//            pending, full   - pending-drop count and saturation flag
//            overflow        - sticky: a drop request was clipped
//            num_dropped     - discarded-response counter (wraps at 2^16)
// Revision : 1.0 - initial release
//============================================================================
module lab2_proc_multi_drop_unit #(
  parameter int p_msg_nbits = 47,
  parameter int p_max_drops = 3,
  localparam int c_cnt_nbits = $clog2(p_max_drops + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   drop,
  input  logic [c_cnt_nbits-1:0] drop_num,
  input  logic [p_msg_nbits-1:0] in_msg,
  input  logic                   in_val,
  output logic                   in_rdy,
  output logic [p_msg_nbits-1:0] out_msg,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [c_cnt_nbits-1:0] pending,
  output logic                   full,
  output logic                   overflow,
  output logic [15:0]            num_dropped
);

  localparam logic [c_cnt_nbits:0]   c_max_ext = (c_cnt_nbits + 1)'(p_max_drops);
  localparam logic [c_cnt_nbits-1:0] c_max_cnt = c_cnt_nbits'(p_max_drops);

  logic [c_cnt_nbits-1:0] r_pending;
  logic                   r_overflow;
  logic [15:0]            r_num_dropped;

  logic                 w_dropping;
  logic                 w_consume;
  logic [c_cnt_nbits:0] w_add;
  logic [c_cnt_nbits:0] w_sub;
  logic [c_cnt_nbits:0] w_sum;
  logic [c_cnt_nbits:0] w_next;

  // A same-cycle drop already applies to a response arriving this cycle.
  assign w_dropping = (r_pending != '0) | drop;
  assign w_consume  = w_dropping & in_val & ~reset;

  // Handshake: a doomed response is always accepted regardless of the
  // F stage; otherwise the F stage's ready is passed straight through.
  always_comb begin
    in_rdy  = 1'b0;
    out_val = 1'b0;
    if (!reset) begin
      if (w_dropping) begin
        in_rdy  = in_val ? 1'b1 : out_rdy;
        out_val = 1'b0;
      end else begin
        in_rdy  = out_rdy;
        out_val = in_val;
      end
    end
  end

  assign out_msg = in_msg;

  // Counter arithmetic one bit wider than the count so add cannot wrap.
  // The floor at zero only matters for an illegal drop with drop_num=0.
  assign w_add  = drop ? {1'b0, drop_num} : '0;
  assign w_sub  = {{c_cnt_nbits{1'b0}}, w_consume};
  assign w_sum  = {1'b0, r_pending} + w_add;
  assign w_next = (w_sum >= w_sub) ? (w_sum - w_sub) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending     <= '0;
      r_overflow    <= 1'b0;
      r_num_dropped <= '0;
    end else begin
      if (w_next > c_max_ext) begin
        r_pending  <= c_max_cnt;
        r_overflow <= 1'b1;
      end else begin
        r_pending  <= w_next[c_cnt_nbits-1:0];
      end
      if (w_consume) begin
        r_num_dropped <= r_num_dropped + 16'd1;
      end
    end
  end

  assign pending     = r_pending;
  assign full        = (r_pending == c_max_cnt);
  assign overflow    = r_overflow;
  assign num_dropped = r_num_dropped;

endmodule
`default_nettype wire

// File: doc/lab2_proc_multi_drop_unit.md
# lab2_proc_multi_drop_unit

Parametrised successor to the single-shot imem response drop unit, sitting between the instruction-memory response port and the F stage of the pipelined processor. Tracks multiple outstanding squashed fetches with a saturating pending-drop counter and discards that many subsequent responses. This makes deeper imem request queues (2+ in flight) safe under back-to-back redirects. Also exposes occupancy, overflow and drop statistics.

## Interface

- p_msg_nbits, 47: width of the passed-through response message (mem_resp_4B_t).
- p_max_drops, 3: maximum pending drops held; c_cnt_nbits = $clog2(p_max_drops+1).
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- drop  input  1  squash event this cycle; adds drop_num pending drops.
- drop_num  input  c_cnt_nbits  number of in-flight responses to discard (≥1 when drop=1; ignored when drop=0).
- in_msg  input  p_msg_nbits  response from memory.
- in_val  input  1  response valid.
- in_rdy  output  1  response accepted.
- out_msg  output  p_msg_nbits  response to F stage (combinational copy of in_msg).
- out_val  output  1  forwarded response valid.
- out_rdy  input  1  F stage ready.
- pending  output  c_cnt_nbits  current pending-drop count (register).
- full  output  1  pending == p_max_drops.
- overflow  output  1  sticky error: a drop request was saturated.
- num_dropped  output  16  count of discarded responses, wraps modulo 2^16.

## Operation

- dropping = (pending != 0) | drop. A same-cycle drop applies to a response arriving in that cycle.
- Drop path (dropping & in_val):
  - in_rdy=1 and out_val=0, independent of out_rdy.
  - The response is consumed and discarded; num_dropped increments.
- Pass path (!dropping):
  - out_val = in_val, in_rdy = out_rdy, out_msg = in_msg.
  - No state change.
- When dropping & !in_val: in_rdy = out_rdy, out_val = 0.
- Counter update:
  - add = drop ? drop_num : 0
  - sub = (dropping & in_val) ? 1 : 0
  - next = pending + add − sub, computed at c_cnt_nbits+1 bits.
  - If next > p_max_drops: pending ← p_max_drops and overflow ← 1.
  - Otherwise pending ← next.
- overflow is cleared only by reset.
- No FSM beyond the counter. Conceptually IDLE (pending=0) and DRAINING (pending>0):
  - IDLE→DRAINING when drop asserted and add > sub.
  - DRAINING→IDLE when the last pending response is consumed and no new drop arrives.

## Timing

- Zero-latency combinational forwarding. in_msg→out_msg, in_val→out_val and out_rdy→in_rdy are combinational paths.
- drop and drop_num affect out_val/in_rdy in the same cycle. pending reflects the update on the next edge.
- Reset (synchronous, one cycle): pending=0, overflow=0, num_dropped=0, out_val=0.
  - During reset, in_rdy=0; drop and in_val are ignored.
- Reset mid-drain discards all pending drops. The next response after reset is forwarded.
- Simultaneous drop=1, drop_num=1, in_val=1 with pending=0: the response is dropped and pending stays 0.
- Simultaneous drop with pending=p_max_drops and in_val=1: net add is drop_num−1. Saturation applies only if the result exceeds the maximum.
- num_dropped wraps 0xFFFF→0x0000 with no flag.

## Test plan

- Passthrough: pending=0, in_val=1, in_msg=0x1234, out_rdy=0 → out_val=1, in_rdy=0. Raise out_rdy → in_rdy=1; pending stays 0.
- Same-cycle drop: drop=1, drop_num=1, in_val=1 → out_val=0, in_rdy=1, num_dropped=1, pending stays 0. Next response is forwarded.
- Multi-drop: drop=1, drop_num=2, in_val=0 → pending=2. Next two responses (out_rdy=0) are both consumed with out_val=0. Third response is forwarded; num_dropped=2.
- Saturation (p_max_drops=3): pending=3, full=1, drop=1, drop_num=2, in_val=1 → pending=3, overflow=1. Overflow persists until reset.
- Reset mid-drain: pending=2, assert reset one cycle → pending=0, overflow=0, num_dropped=0. Next in_val forwarded immediately.
- Wrap: preload by dropping 65536 responses → num_dropped=0x0000, with no other side effects.
